pipelined_chunk_adder: RTL and testbench

Parametrised carry-pipelined adder/subtractor. It splits a WIDTH-bit operation into WIDTH/CHUNK ripple chunks and registers the carry between chunks, giving one chunk per clock stage. It accepts one operation per cycle under a valid/ready handshake and adds subtract mode and a signed-overflow flag. It is the successor to the team's combinational chained-chunk adders, for datapaths where a full-width ripple cannot close timing.

---
 rtl/pipelined_chunk_adder.sv | 120 ++++++++++++
 tb/tb_pipelined_chunk_adder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_chunk_adder.sv
// Carry-pipelined adder/subtractor: WIDTH bits split into CHUNK-bit ripple stages,
// one stage per clock, valid/ready handshake with a global stall.
module pipelined_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int CS     = (CHUNK < 1) ? 1 : CHUNK;
  localparam int STAGES = WIDTH / CS;
  localparam int L      = STAGES - 1;

  if (CHUNK < 1 || (WIDTH % CS) != 0 || WIDTH < CS) begin : g_bad_param
    $error("pipelined_chunk_adder: WIDTH must be a non-zero multiple of CHUNK, CHUNK >= 1");
  end

  logic             adv;
  logic [WIDTH-1:0] yb;
  logic             cin;

  assign yb  = sub ? ~y : y;
  assign cin = sub ? ~ci : ci;

  // Every stage moves together; a full output register that is not taken freezes the pipe.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // Stage k sees the operand bits from chunk k upward; lower chunks are already summed.
    localparam int RW = WIDTH - k * CS;

    logic                  v_i;
    logic                  c_i;
    logic [RW-1:0]         x_i;
    logic [RW-1:0]         y_i;
    logic [(k+1)*CS-1:0]   s_n;
    logic [CS:0]           csum;

    logic                  v_q;
    logic                  c_q;
    logic [(k+1)*CS-1:0]   s_q;

    if (k == 0) begin : g_first
      assign v_i = in_valid;
      assign c_i = cin;
      assign x_i = x;
      assign y_i = yb;
      assign s_n = csum[CS-1:0];
    end else begin : g_next
      assign v_i = g_st[k-1].v_q;
      assign c_i = g_st[k-1].c_q;
      assign x_i = g_st[k-1].g_fwd.x_q;
      assign y_i = g_st[k-1].g_fwd.y_q;
      assign s_n = {csum[CS-1:0], g_st[k-1].s_q};
    end

    assign csum = {1'b0, x_i[CS-1:0]} + {1'b0, y_i[CS-1:0]} + {{CS{1'b0}}, c_i};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_i;
        if (v_i) begin
          c_q <= csum[CS];
          s_q <= s_n;
        end
      end
    end

    if (k < L) begin : g_fwd
      logic [RW-CS-1:0] x_q;
      logic [RW-CS-1:0] y_q;

      always_ff @(posedge clk) begin
        if (adv && v_i) begin
          x_q <= x_i[RW-1:CS];
          y_q <= y_i[RW-1:CS];
        end
      end
    end

    if (k == L) begin : g_last
      logic ovf_n;
      logic ovf_q;

      // a ^ b ^ sum recovers the carry into the MSB; xor with carry-out gives signed overflow.
      assign ovf_n = x_i[CS-1] ^ y_i[CS-1] ^ csum[CS-1] ^ csum[CS];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv && v_i) begin
          ovf_q <= ovf_n;
        end
      end
    end
  end

  assign out_valid = g_st[L].v_q;
  assign co        = g_st[L].c_q;
  assign s         = g_st[L].s_q;
  assign ovf       = g_st[L].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// Bench for pipelined_chunk_adder: three configurations (32/8, 12/4, 16/16) against
// an arithmetic reference model with randomized streams, stalls and async reset.
module tb_pipelined_chunk_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        iv[3], civ[3], subv[3], orv[3];
  logic [31:0] xv[3], yv[3];
  logic        ir[3], ov[3], cov[3], ovfv[3];
  logic [31:0] sv[3];

  logic        ir0, ov0, co0, f0;
  logic        ir1, ov1, co1, f1;
  logic        ir2, ov2, co2, f2;
  logic [31:0] s0;
  logic [11:0] s1;
  logic [15:0] s2;

  pipelined_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .x(xv[0]), .y(yv[0]),
    .ci(civ[0]), .sub(subv[0]), .out_valid(ov0), .out_ready(orv[0]), .s(s0), .co(co0), .ovf(f0));

  pipelined_chunk_adder #(.WIDTH(12), .CHUNK(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .x(xv[1][11:0]), .y(yv[1][11:0]),
    .ci(civ[1]), .sub(subv[1]), .out_valid(ov1), .out_ready(orv[1]), .s(s1), .co(co1), .ovf(f1));

  pipelined_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2), .x(xv[2][15:0]), .y(yv[2][15:0]),
    .ci(civ[2]), .sub(subv[2]), .out_valid(ov2), .out_ready(orv[2]), .s(s2), .co(co2), .ovf(f2));

  assign ir[0] = ir0;  assign ov[0] = ov0;  assign cov[0] = co0;  assign ovfv[0] = f0;
  assign ir[1] = ir1;  assign ov[1] = ov1;  assign cov[1] = co1;  assign ovfv[1] = f1;
  assign ir[2] = ir2;  assign ov[2] = ov2;  assign cov[2] = co2;  assign ovfv[2] = f2;
  assign sv[0] = s0;
  assign sv[1] = {20'b0, s1};
  assign sv[2] = {16'b0, s2};

  function automatic int wid(input int d);
    return (d == 0) ? 32 : ((d == 1) ? 12 : 16);
  endfunction

  function automatic int stages(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 3 : 1);
  endfunction

  function automatic logic [31:0] wmask(input int d);
    return (d == 0) ? 32'hFFFF_FFFF : ((d == 1) ? 32'h0000_0FFF : 32'h0000_FFFF);
  endfunction

  // Reference: result = x + (sub ? ~y : y) + (sub ? !ci : ci) over w bits; returns {ovf, co, s}.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic c, input logic sb);
    longint unsigned m, aa, bb, t, r;
    logic cout, ovr;
    m  = (64'd1 << w) - 64'd1;
    aa = {32'b0, a} & m;
    bb = sb ? (~{32'b0, b}) & m : ({32'b0, b} & m);
    t  = aa + bb + ((sb ? !c : c) ? 64'd1 : 64'd0);
    r  = t & m;
    cout = t[w];
    ovr  = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
    return {ovr, cout, r[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; orv[d] = 1'b1; xv[d] = '0; yv[d] = '0; civ[d] = 1'b0; subv[d] = 1'b0;
    end
    rst = 1'b1;
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if ({ov[d], cov[d], ovfv[d], sv[d]} !== 35'd0) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: got ov=%b co=%b ovf=%b s=%h want all zero",
                 d, ov[d], cov[d], ovfv[d], sv[d]);
      end
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (ir[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL in_ready_after_reset dut%0d: got %b want 1", d, ir[d]);
      end
    end
    tick();
  endtask

  // One isolated operation: checks acceptance, latency, result and that it is delivered once.
  task automatic single_op(input int d, input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic c, input logic sb, input logic [31:0] es,
                           input logic eco, input logic eovf);
    int edges;
    iv[d] = 1'b1; xv[d] = a; yv[d] = b; civ[d] = c; subv[d] = sb; orv[d] = 1'b1;
    #1;
    vectors++;
    if (ir[d] !== 1'b1) begin
      miscompares++;
      $display("FAIL %s in_ready: got %b want 1", name, ir[d]);
    end
    tick();
    iv[d] = 1'b0;
    edges = 1;
    while (!ov[d] && edges < 20) begin
      tick();
      edges++;
    end
    vectors++;
    if (edges != stages(d)) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want %0d", name, edges, stages(d));
    end
    vectors++;
    if ({ov[d], sv[d], cov[d], ovfv[d]} !== {1'b1, es, eco, eovf}) begin
      miscompares++;
      $display("FAIL %s result: got v=%b s=%h co=%b ovf=%b want v=1 s=%h co=%b ovf=%b",
               name, ov[d], sv[d], cov[d], ovfv[d], es, eco, eovf);
    end
    tick();
    vectors++;
    if (ov[d] !== 1'b0) begin
      miscompares++;
      $display("FAIL %s duplicate: got out_valid=%b want 0", name, ov[d]);
    end
  endtask

  task automatic test_directed();
    single_op(0, "ripple_all",  32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    single_op(0, "add_ovf",     32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    single_op(0, "sub_ovf",     32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    single_op(0, "sub_neg",     32'h5,         32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    single_op(0, "sub_borrow",  32'h5,         32'h7, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0);
  endtask

  // Random stream with an optional out_ready stall window; returns first/last output cycle.
  task automatic run_stream(input int d, input int n, input int stall_at, input int stall_len,
                            output int first, output int last);
    logic [33:0] expq[$];
    logic [33:0] e, held;
    int cyc, sent, recv;
    bit held_ok;
    cyc = 0; sent = 0; recv = 0; held_ok = 0; first = -1; last = -1; held = '0;
    while (recv < n && cyc < 300) begin
      if (sent < n) begin
        iv[d]   = 1'b1;
        xv[d]   = $urandom() & wmask(d);
        yv[d]   = $urandom() & wmask(d);
        civ[d]  = 1'($urandom_range(0, 1));
        subv[d] = 1'($urandom_range(0, 1));
      end else begin
        iv[d] = 1'b0;
      end
      orv[d] = !(cyc >= stall_at && cyc < stall_at + stall_len);
      @(negedge clk);
      vectors++;
      if (ir[d] !== (!ov[d] || orv[d])) begin
        miscompares++;
        $display("FAIL in_ready dut%0d cyc%0d: got %b want %b", d, cyc, ir[d], !ov[d] || orv[d]);
      end
      if (ov[d]) begin
        if (held_ok) begin
          vectors++;
          if ({ovfv[d], cov[d], sv[d]} !== held) begin
            miscompares++;
            $display("FAIL stall_hold dut%0d cyc%0d: got %h want %h", d, cyc,
                     {ovfv[d], cov[d], sv[d]}, held);
          end
        end
        if (orv[d]) begin
          vectors++;
          if (expq.size() == 0) begin
            miscompares++;
            $display("FAIL extra_output dut%0d cyc%0d: got s=%h want no output", d, cyc, sv[d]);
          end else begin
            e = expq.pop_front();
            if ({ovfv[d], cov[d], sv[d]} !== e) begin
              miscompares++;
              $display("FAIL stream dut%0d cyc%0d: got ovf/co/s=%h want %h", d, cyc,
                       {ovfv[d], cov[d], sv[d]}, e);
            end
          end
          recv++;
          if (first < 0) first = cyc;
          last = cyc;
          held_ok = 0;
        end else begin
          held = {ovfv[d], cov[d], sv[d]};
          held_ok = 1;
        end
      end
      if (iv[d] && ir[d]) begin
        expq.push_back(model(wid(d), xv[d], yv[d], civ[d], subv[d]));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    iv[d] = 1'b0;
    orv[d] = 1'b1;
    vectors++;
    if (recv != n) begin
      miscompares++;
      $display("FAIL stream_timeout dut%0d: got %0d results want %0d", d, recv, n);
    end
  endtask

  task automatic test_back_to_back();
    int first, last;
    run_stream(0, 10, -1, 0, first, last);
    vectors++;
    if (last - first != 9) begin
      miscompares++;
      $display("FAIL back_to_back_gaps: got span %0d want 9", last - first);
    end
    tick();
  endtask

  task automatic test_stall();
    int first, last;
    run_stream(0, 12, 5, 3, first, last);
    vectors++;
    if (last - first != 14) begin
      miscompares++;
      $display("FAIL stall_span: got span %0d want 14", last - first);
    end
    tick();
  endtask

  task automatic test_async_reset();
    logic [33:0] e;
    int stray;
    orv[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[0] = 1'b1; xv[0] = $urandom(); yv[0] = $urandom();
      civ[0] = 1'($urandom_range(0, 1)); subv[0] = 1'($urandom_range(0, 1));
      tick();
    end
    iv[0] = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if ({ov[0], cov[0], ovfv[0], sv[0]} !== 35'd0) begin
      miscompares++;
      $display("FAIL async_reset: got ov=%b co=%b ovf=%b s=%h want all zero",
               ov[0], cov[0], ovfv[0], sv[0]);
    end
    #1;
    rst = 1'b0;
    #1;
    vectors++;
    if (ir[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL in_ready_post_reset: got %b want 1", ir[0]);
    end
    tick();
    xv[0] = $urandom(); yv[0] = $urandom(); civ[0] = 1'($urandom_range(0, 1));
    subv[0] = 1'($urandom_range(0, 1));
    e = model(32, xv[0], yv[0], civ[0], subv[0]);
    single_op(0, "post_reset_op", xv[0], yv[0], civ[0], subv[0], e[31:0], e[32], e[33]);
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ov[0]) stray++;
    end
    vectors++;
    if (stray != 0) begin
      miscompares++;
      $display("FAIL post_reset_stray: got %0d extra outputs want 0", stray);
    end
  endtask

  task automatic test_other_widths();
    int first, last;
    logic [33:0] e;
    for (int d = 1; d < 3; d++) begin
      xv[d] = $urandom() & wmask(d); yv[d] = $urandom() & wmask(d);
      civ[d] = 1'($urandom_range(0, 1)); subv[d] = 1'($urandom_range(0, 1));
      e = model(wid(d), xv[d], yv[d], civ[d], subv[d]);
      single_op(d, (d == 1) ? "w12_single" : "w16_single", xv[d], yv[d], civ[d], subv[d],
                e[31:0], e[32], e[33]);
    end
    single_op(1, "w12_ovf", 32'h7FF, 32'h1, 1'b0, 1'b0, 32'h800, 1'b0, 1'b1);
    single_op(2, "w16_sub", 32'h8000, 32'h1, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1);
    run_stream(1, 20, 4, 2, first, last);
    tick();
    run_stream(2, 20, 3, 3, first, last);
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_async_reset();
    test_other_widths();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
